sparc_ifu_parchk: RTL and testbench
===================================

# sparc_ifu_parchk

Instruction-fetch parity checker that sits directly downstream of the IFU 16-bit parity generators. Each checked 64-bit fetch doubleword arrives as four recomputed halfword parities, from four generator instances, plus the four parity bits stored in the I$ data array. The block compares them and registers a per-fetch error flag and mismatch mask. It captures the first error in a sticky log and holds a request to the trap/error logic until acknowledged. It also keeps a saturating error count.

## Interface
Parameters:
- IDX_W, 7, width of the I$ set index carried with each check.
- CNT_W, 8, width of the saturating error counter.

Ports:
- rclk  in  1  core clock; all state updates on its rising edge.
- arst_l  in  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- chk_vld_f  in  1  a doubleword is presented for checking this cycle.
- calc_par_f  in  4  recomputed parity per halfword; bit i covers data[16i+15:16i]; 1 = odd number of ones.
- stored_par_f  in  4  parity bits read from the data array, same bit ordering.
- chk_tid_f  in  2  fetching thread.
- chk_way_f  in  2  I$ way hit.
- chk_idx_f  in  IDX_W  I$ set index.
- dis_chk  in  1  checking disable (ASI-controlled); sampled every cycle together with chk_vld_f.
- err_ack  in  1  error logic has consumed the log.
- par_err_s  out  1  registered: the fetch checked in the previous cycle mismatched.
- par_err_hw_s  out  4  registered mismatch mask for that fetch.
- err_req  out  1  log valid, request pending.
- err_log_tid  out  2  logged thread.
- err_log_way  out  2  logged way.
- err_log_idx  out  IDX_W  logged index.
- err_log_hw  out  4  logged mismatch mask.
- err_log_ovf  out  1  another error arrived while the log was pending.
- err_cnt  out  CNT_W  saturating count of erroneous fetches.

## Operation
- Mismatch vector (combinational, cycle N): mm = (calc_par_f ^ stored_par_f) & {4{chk_vld_f & ~dis_chk}}. err_n = |mm.
- Pipeline register: par_err_hw_s <= mm and par_err_s <= err_n on every edge, unconditionally. Both are 0 in any cycle following a non-valid or disabled cycle.
- Log FSM, two states:
  - IDLE: err_req=0.
  - PEND: err_req=1, log fields stable.
- IDLE, err_n=1 -> PEND. Capture tid/way/idx/mm into the log. err_log_ovf <= 0.
- IDLE, err_n=0 -> IDLE. err_ack ignored.
- PEND, err_ack=0, err_n=1 -> PEND. Log fields unchanged. err_log_ovf <= 1.
- PEND, err_ack=1, err_n=0 -> IDLE. Log fields are held, not cleared. err_log_ovf <= 0.
- PEND, err_ack=1, err_n=1 -> PEND. The new error overwrites the log. err_log_ovf <= 0 (the old entry is consumed, so nothing is lost).
- Counter: err_cnt increments by 1 on each cycle with err_n=1, regardless of how many bits are set in mm or of FSM state. It holds at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- dis_chk=1 suppresses err_n entirely: no flag, no log, no count. It does not affect a pending log or err_ack handling.

## Timing
- Reset values (asynchronous on arst_l=0): par_err_s=0, par_err_hw_s=0, FSM=IDLE, err_req=0, all err_log_* = 0, err_cnt=0.
- Reset release: first update on the first rising rclk edge with arst_l=1.
- Latency: a valid check in cycle N produces par_err_s/par_err_hw_s in N+1. If it is the capturing error, err_req and log fields are also valid in N+1.
- err_ack is sampled on the same edge as err_n. An ack in cycle M makes err_req=0 from M+1, unless an error arrives in M.
- One check per cycle, sustained. No back-pressure on the fetch side; errors during PEND are never stalled, only flagged through ovf.
- No combinational path from any input to any output.

## Test plan
- Reset: drive random inputs with arst_l=0 -> every output is 0. After release, calc=4'b1010 and stored=4'b1010 with vld=1 -> par_err_s=0, err_cnt=0.
- Single error: vld=1, tid=2, way=1, idx=7'h35, calc=4'b0110, stored=4'b0100 -> next cycle par_err_s=1, par_err_hw_s=4'b0010, err_req=1, log={2,1,7'h35,4'b0010}, err_cnt=1. Ack one cycle later -> err_req=0 the following cycle.
- Overflow then ack collision: error A captured. Error B with no ack -> err_log_ovf=1 and log still shows A. Error C with err_ack=1 in the same cycle -> log shows C, ovf=0, err_req stays 1. err_cnt=3.
- Disable: dis_chk=1 with calc!=stored for 10 cycles -> par_err_s=0, err_req=0, err_cnt unchanged. A pending log is still cleared by err_ack.
- Saturation (CNT_W=3): 9 back-to-back erroneous fetches -> err_cnt reads 1..7, then holds at 7. Mask 4'b1111 counts as 1 per fetch.
- Mid-operation reset: arst_l=0 while in PEND with ovf=1 -> err_req, log and err_cnt drop to 0 immediately, without waiting for rclk.

Source files
------------

// File: rtl/sparc_ifu_parchk.sv
// Compares recomputed I$ halfword parities with stored parity for each fetch.
// Registers a per-fetch error flag, keeps a sticky first-error log and a saturating error count.
module sparc_ifu_parchk #(
   parameter int IDX_W = 7,
   parameter int CNT_W = 8
) (
   input  logic             rclk,
   input  logic             arst_l,
   input  logic             chk_vld_f,
   input  logic [3:0]       calc_par_f,
   input  logic [3:0]       stored_par_f,
   input  logic [1:0]       chk_tid_f,
   input  logic [1:0]       chk_way_f,
   input  logic [IDX_W-1:0] chk_idx_f,
   input  logic             dis_chk,
   input  logic             err_ack,
   output logic             par_err_s,
   output logic [3:0]       par_err_hw_s,
   output logic             err_req,
   output logic [1:0]       err_log_tid,
   output logic [1:0]       err_log_way,
   output logic [IDX_W-1:0] err_log_idx,
   output logic [3:0]       err_log_hw,
   output logic             err_log_ovf,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   logic [3:0]       w_mm;
   logic             w_err;
   state_t           r_state;
   logic             r_par_err;
   logic [3:0]       r_par_err_hw;
   logic [1:0]       r_log_tid;
   logic [1:0]       r_log_way;
   logic [IDX_W-1:0] r_log_idx;
   logic [3:0]       r_log_hw;
   logic             r_log_ovf;
   logic [CNT_W-1:0] r_cnt;

   assign w_mm  = (calc_par_f ^ stored_par_f) & {4{chk_vld_f & ~dis_chk}};
   assign w_err = |w_mm;

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         r_par_err    <= 1'b0;
         r_par_err_hw <= 4'b0;
      end else begin
         r_par_err    <= w_err;
         r_par_err_hw <= w_mm;
      end
   end

   // A new error overwrites the log only when nothing is pending or the pending entry is being acked.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         r_state   <= ST_IDLE;
         r_log_tid <= 2'b0;
         r_log_way <= 2'b0;
         r_log_idx <= '0;
         r_log_hw  <= 4'b0;
         r_log_ovf <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_err) begin
                  r_state   <= ST_PEND;
                  r_log_tid <= chk_tid_f;
                  r_log_way <= chk_way_f;
                  r_log_idx <= chk_idx_f;
                  r_log_hw  <= w_mm;
                  r_log_ovf <= 1'b0;
               end
            end
            ST_PEND: begin
               if (err_ack && w_err) begin
                  r_log_tid <= chk_tid_f;
                  r_log_way <= chk_way_f;
                  r_log_idx <= chk_idx_f;
                  r_log_hw  <= w_mm;
                  r_log_ovf <= 1'b0;
               end else if (err_ack) begin
                  r_state   <= ST_IDLE;
                  r_log_ovf <= 1'b0;
               end else if (w_err) begin
                  r_log_ovf <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         r_cnt <= '0;
      end else if (w_err && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign par_err_s    = r_par_err;
   assign par_err_hw_s = r_par_err_hw;
   assign err_req      = (r_state == ST_PEND);
   assign err_log_tid  = r_log_tid;
   assign err_log_way  = r_log_way;
   assign err_log_idx  = r_log_idx;
   assign err_log_hw   = r_log_hw;
   assign err_log_ovf  = r_log_ovf;
   assign err_cnt      = r_cnt;

endmodule

// File: tb/tb_sparc_ifu_parchk.sv
// Directed-vector bench for sparc_ifu_parchk; a second instance with a 3-bit counter
// shares the stimulus so counter saturation can be observed.
module tb_sparc_ifu_parchk;

   logic       rclk;
   logic       arst_l;
   logic       chk_vld_f;
   logic [3:0] calc_par_f;
   logic [3:0] stored_par_f;
   logic [1:0] chk_tid_f;
   logic [1:0] chk_way_f;
   logic [6:0] chk_idx_f;
   logic       dis_chk;
   logic       err_ack;

   logic       par_err_s;
   logic [3:0] par_err_hw_s;
   logic       err_req;
   logic [1:0] err_log_tid;
   logic [1:0] err_log_way;
   logic [6:0] err_log_idx;
   logic [3:0] err_log_hw;
   logic       err_log_ovf;
   logic [7:0] err_cnt;

   logic       satParErr;
   logic [3:0] satParErrHw;
   logic       satErrReq;
   logic [1:0] satLogTid;
   logic [1:0] satLogWay;
   logic [6:0] satLogIdx;
   logic [3:0] satLogHw;
   logic       satLogOvf;
   logic [2:0] satCnt;

   int compared;
   int mismatched;

   sparc_ifu_parchk #(.IDX_W(7), .CNT_W(8)) dut (
      .rclk(rclk), .arst_l(arst_l), .chk_vld_f(chk_vld_f),
      .calc_par_f(calc_par_f), .stored_par_f(stored_par_f),
      .chk_tid_f(chk_tid_f), .chk_way_f(chk_way_f), .chk_idx_f(chk_idx_f),
      .dis_chk(dis_chk), .err_ack(err_ack),
      .par_err_s(par_err_s), .par_err_hw_s(par_err_hw_s), .err_req(err_req),
      .err_log_tid(err_log_tid), .err_log_way(err_log_way),
      .err_log_idx(err_log_idx), .err_log_hw(err_log_hw),
      .err_log_ovf(err_log_ovf), .err_cnt(err_cnt)
   );

   sparc_ifu_parchk #(.IDX_W(7), .CNT_W(3)) dutSat (
      .rclk(rclk), .arst_l(arst_l), .chk_vld_f(chk_vld_f),
      .calc_par_f(calc_par_f), .stored_par_f(stored_par_f),
      .chk_tid_f(chk_tid_f), .chk_way_f(chk_way_f), .chk_idx_f(chk_idx_f),
      .dis_chk(dis_chk), .err_ack(err_ack),
      .par_err_s(satParErr), .par_err_hw_s(satParErrHw), .err_req(satErrReq),
      .err_log_tid(satLogTid), .err_log_way(satLogWay),
      .err_log_idx(satLogIdx), .err_log_hw(satLogHw),
      .err_log_ovf(satLogOvf), .err_cnt(satCnt)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Drives one fetch, then returns 1ns after the capturing edge so outputs can be sampled.
   task automatic applyStimulus(input logic vld, input logic [3:0] calc, input logic [3:0] stored,
                                input logic [1:0] tid, input logic [1:0] way, input logic [6:0] idx,
                                input logic dis, input logic ack);
      chk_vld_f    = vld;
      calc_par_f   = calc;
      stored_par_f = stored;
      chk_tid_f    = tid;
      chk_way_f    = way;
      chk_idx_f    = idx;
      dis_chk      = dis;
      err_ack      = ack;
      @(posedge rclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkLog(input string tag, input logic [1:0] tid, input logic [1:0] way,
                           input logic [6:0] idx, input logic [3:0] hw, input logic ovf);
      checkOutput({tag, "_tid"}, {30'b0, err_log_tid}, {30'b0, tid});
      checkOutput({tag, "_way"}, {30'b0, err_log_way}, {30'b0, way});
      checkOutput({tag, "_idx"}, {25'b0, err_log_idx}, {25'b0, idx});
      checkOutput({tag, "_hw"},  {28'b0, err_log_hw},  {28'b0, hw});
      checkOutput({tag, "_ovf"}, {31'b0, err_log_ovf}, {31'b0, ovf});
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      // Reset held with random inputs: every output must be zero
      arst_l       = 1'b0;
      chk_vld_f    = 1'b1;
      calc_par_f   = 4'($urandom);
      stored_par_f = ~calc_par_f;
      chk_tid_f    = 2'($urandom);
      chk_way_f    = 2'($urandom);
      chk_idx_f    = 7'($urandom);
      dis_chk      = 1'b0;
      err_ack      = 1'($urandom);
      repeat (2) @(posedge rclk);
      #1;
      checkOutput("rst_par_err", {31'b0, par_err_s}, 32'd0);
      checkOutput("rst_par_hw", {28'b0, par_err_hw_s}, 32'd0);
      checkOutput("rst_req", {31'b0, err_req}, 32'd0);
      checkLog("rst_log", 2'd0, 2'd0, 7'h00, 4'b0000, 1'b0);
      checkOutput("rst_cnt", {24'b0, err_cnt}, 32'd0);

      @(negedge rclk);
      arst_l = 1'b1;

      applyStimulus(1'b1, 4'b1010, 4'b1010, 2'd0, 2'd0, 7'h00, 1'b0, 1'b0);
      checkOutput("match_par_err", {31'b0, par_err_s}, 32'd0);
      checkOutput("match_cnt", {24'b0, err_cnt}, 32'd0);

      // Single error is captured and visible one cycle later
      applyStimulus(1'b1, 4'b0110, 4'b0100, 2'd2, 2'd1, 7'h35, 1'b0, 1'b0);
      checkOutput("single_par_err", {31'b0, par_err_s}, 32'd1);
      checkOutput("single_par_hw", {28'b0, par_err_hw_s}, 32'h2);
      checkOutput("single_req", {31'b0, err_req}, 32'd1);
      checkLog("single_log", 2'd2, 2'd1, 7'h35, 4'b0010, 1'b0);
      checkOutput("single_cnt", {24'b0, err_cnt}, 32'd1);

      applyStimulus(1'b0, 4'b1111, 4'b0000, 2'd0, 2'd0, 7'h00, 1'b0, 1'b1);
      checkOutput("ack_req", {31'b0, err_req}, 32'd0);
      checkOutput("ack_par_err", {31'b0, par_err_s}, 32'd0);
      checkOutput("ack_log_held", {28'b0, err_log_hw}, 32'h2);

      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0, 7'h00, 1'b0, 1'b1);
      checkOutput("idle_ack_req", {31'b0, err_req}, 32'd0);

      // Error A captured, B overflows, C collides with ack and replaces the log
      applyStimulus(1'b1, 4'b0001, 4'b0000, 2'd1, 2'd3, 7'h11, 1'b0, 1'b0);
      checkOutput("a_req", {31'b0, err_req}, 32'd1);
      checkLog("a_log", 2'd1, 2'd3, 7'h11, 4'b0001, 1'b0);

      applyStimulus(1'b1, 4'b1100, 4'b0000, 2'd3, 2'd0, 7'h22, 1'b0, 1'b0);
      checkOutput("b_par_hw", {28'b0, par_err_hw_s}, 32'hc);
      checkLog("b_log", 2'd1, 2'd3, 7'h11, 4'b0001, 1'b1);
      checkOutput("b_cnt", {24'b0, err_cnt}, 32'd3);

      applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 2'd2, 7'h7f, 1'b0, 1'b1);
      checkOutput("c_req", {31'b0, err_req}, 32'd1);
      checkLog("c_log", 2'd0, 2'd2, 7'h7f, 4'b1111, 1'b0);
      checkOutput("c_cnt", {24'b0, err_cnt}, 32'd4);

      // Disabled checking: mismatches ignored, pending log untouched
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 4'b0101, 4'b1010, 2'd1, 2'd1, 7'h01, 1'b1, 1'b0);
         checkOutput("dis_par_err", {31'b0, par_err_s}, 32'd0);
         checkOutput("dis_cnt", {24'b0, err_cnt}, 32'd4);
      end
      checkOutput("dis_req_held", {31'b0, err_req}, 32'd1);
      checkLog("dis_log", 2'd0, 2'd2, 7'h7f, 4'b1111, 1'b0);

      applyStimulus(1'b1, 4'b0101, 4'b1010, 2'd1, 2'd1, 7'h01, 1'b1, 1'b1);
      checkOutput("dis_ack_req", {31'b0, err_req}, 32'd0);
      checkOutput("dis_ack_cnt", {24'b0, err_cnt}, 32'd4);

      // Fresh reset, then 9 back-to-back full-mask errors to saturate the 3-bit counter
      arst_l = 1'b0;
      #1;
      arst_l = 1'b1;
      checkOutput("rst2_cnt", {24'b0, err_cnt}, 32'd0);
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd3, 2'd2, 7'h40, 1'b0, 1'b0);
         checkOutput("sat_cnt3", {29'b0, satCnt}, (i > 7) ? 32'd7 : 32'(i));
         checkOutput("sat_cnt8", {24'b0, err_cnt}, 32'(i));
      end
      checkOutput("sat_req", {31'b0, satErrReq}, 32'd1);
      checkOutput("sat_ovf", {31'b0, err_log_ovf}, 32'd1);

      // Asynchronous reset mid-PEND, checked before the next clock edge
      #2;
      arst_l = 1'b0;
      #1;
      checkOutput("async_req", {31'b0, err_req}, 32'd0);
      checkLog("async_log", 2'd0, 2'd0, 7'h00, 4'b0000, 1'b0);
      checkOutput("async_cnt", {24'b0, err_cnt}, 32'd0);
      checkOutput("async_cnt3", {29'b0, satCnt}, 32'd0);
      checkOutput("async_par_err", {31'b0, par_err_s}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
